// File: rtl/demux_stream_if.sv
// Handshake bundle for demux_stream: one upstream port fanned out to NUM_OUT channels.
// The counter read port exists only when DEMUX_STREAM_COUNT_EN is defined.
interface demux_stream_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic [DATA_W-1:0]  in_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               drop_err;
`ifdef DEMUX_STREAM_COUNT_EN
  logic [SEL_W-1:0]   cnt_sel;
  logic [15:0]        cnt_value;

  modport slave (
    input  in_valid, in_sel, in_data, out_ready, cnt_sel,
    output in_ready, out_valid, out_data, drop_err, cnt_value
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready, cnt_sel,
    input  in_ready, out_valid, out_data, drop_err, cnt_value
  );
`else
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, drop_err
  );

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, drop_err
  );
`endif
endinterface

// File: rtl/demux_stream.sv
// Single-stage stream demultiplexer: routes each word to the channel named by in_sel.
// Define DEMUX_STREAM_COUNT_EN to add saturating per-channel drain counters with a read port.
module demux_stream #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = 3
) (
  input logic           clock,
  input logic           reset,
  demux_stream_if.slave bus
);

  localparam logic [31:0] NUM_OUT_U = 32'(NUM_OUT);

  logic               hold_valid_q, hold_valid_d;
  logic [SEL_W-1:0]   hold_sel_q, hold_sel_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic               drop_err_q, drop_err_d;
  logic               drain;
  logic               accept;
  logic               in_ready;
  logic [NUM_OUT-1:0] out_valid;

  // Only the ready of the currently addressed channel matters; an empty stage always accepts.
  always_comb begin
    drain        = hold_valid_q && bus.out_ready[hold_sel_q];
    in_ready     = !hold_valid_q || drain;
    accept       = bus.in_valid && in_ready;
    hold_valid_d = hold_valid_q;
    hold_sel_d   = hold_sel_q;
    hold_data_d  = hold_data_q;
    drop_err_d   = 1'b0;
    if (drain) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      if (32'(bus.in_sel) < NUM_OUT_U) begin
        hold_valid_d = 1'b1;
        hold_sel_d   = bus.in_sel;
        hold_data_d  = bus.in_data;
      end else begin
        drop_err_d   = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_valid[k] = hold_valid_q && (32'(hold_sel_q) == 32'(k));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_sel_q   <= '0;
      hold_data_q  <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_sel_q   <= hold_sel_d;
      hold_data_q  <= hold_data_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = hold_data_q;
  assign bus.drop_err  = drop_err_q;

`ifdef DEMUX_STREAM_COUNT_EN
  logic [15:0] cnt_q [NUM_OUT];
  logic [15:0] cnt_d [NUM_OUT];
  logic [15:0] cnt_value_q, cnt_value_d;

  // Counters saturate rather than wrap so a long-running channel never reads as idle.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      cnt_d[k] = cnt_q[k];
      if (drain && (32'(hold_sel_q) == 32'(k)) && (cnt_q[k] != 16'hFFFF)) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
    cnt_value_d = '0;
    if (32'(bus.cnt_sel) < NUM_OUT_U) begin
      cnt_value_d = cnt_q[bus.cnt_sel];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        cnt_q[k] <= '0;
      end
      cnt_value_q <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      cnt_value_q <= cnt_value_d;
    end
  end

  assign bus.cnt_value = cnt_value_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: a default 8-channel instance and a 6-channel instance
// that exercises out-of-range selects. Counter checks compile in with DEMUX_STREAM_COUNT_EN.
module tb_demux_stream;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  demux_stream_if #(.DATA_W(8), .NUM_OUT(8), .SEL_W(3)) bus_a ();
  demux_stream_if #(.DATA_W(8), .NUM_OUT(6), .SEL_W(3)) bus_b ();

  demux_stream #(.DATA_W(8), .NUM_OUT(8), .SEL_W(3)) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (bus_a)
  );

  demux_stream #(.DATA_W(8), .NUM_OUT(6), .SEL_W(3)) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (bus_b)
  );

  typedef struct packed {
    logic       drop;
    logic [2:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q [2][$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got empty queue expected a pending word", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic v, input logic [2:0] sel,
                               input logic [7:0] data, input logic [7:0] ready);
    if (id == 0) begin
      bus_a.in_valid  = v;
      bus_a.in_sel    = sel;
      bus_a.in_data   = data;
      bus_a.out_ready = ready;
    end else begin
      bus_b.in_valid  = v;
      bus_b.in_sel    = sel;
      bus_b.in_data   = data;
      bus_b.out_ready = ready[5:0];
    end
    #1;
  endtask

  // Pops on every drain or drop pulse, pushes on every accept; a reset empties the model.
  task automatic checkOutput(input int id, input int num_out, input logic rst,
                             input logic in_valid, input logic in_ready,
                             input logic [2:0] in_sel, input logic [7:0] in_data,
                             input logic [7:0] out_valid, input logic [7:0] out_ready,
                             input logic [7:0] out_data, input logic drop_err);
    exp_t e;
    logic want_ready;
    if (rst) begin
      exp_q[id].delete();
      return;
    end
    check($sformatf("onehot%0d", id), 32'($countones(out_valid) > 1), 32'd0);
    if (drop_err) begin
      if (exp_q[id].size() == 0) begin
        fail_now($sformatf("drop_unexpected%0d", id));
      end else begin
        e = exp_q[id].pop_front();
        check($sformatf("drop_expected%0d", id), 32'(e.drop), 32'd1);
      end
    end
    if ((out_valid & out_ready) != 8'd0) begin
      if (exp_q[id].size() == 0) begin
        fail_now($sformatf("drain_unexpected%0d", id));
      end else begin
        e = exp_q[id].pop_front();
        check($sformatf("drain_drop%0d", id), 32'(e.drop), 32'd0);
        check($sformatf("drain_valid%0d", id), 32'(out_valid), 32'(8'd1 << e.sel));
        check($sformatf("drain_data%0d", id), 32'(out_data), 32'(e.data));
      end
    end
    want_ready = (out_valid == 8'd0) || ((out_valid & out_ready) != 8'd0);
    check($sformatf("in_ready%0d", id), 32'(in_ready), 32'(want_ready));
    if (in_valid && in_ready) begin
      e.drop = (32'(in_sel) >= 32'(num_out));
      e.sel  = in_sel;
      e.data = in_data;
      exp_q[id].push_back(e);
    end
  endtask

  always @(negedge clock) begin
    checkOutput(0, 8, reset, bus_a.in_valid, bus_a.in_ready, bus_a.in_sel, bus_a.in_data,
                bus_a.out_valid, bus_a.out_ready, bus_a.out_data, bus_a.drop_err);
    checkOutput(1, 6, reset, bus_b.in_valid, bus_b.in_ready, bus_b.in_sel, bus_b.in_data,
                8'(bus_b.out_valid), 8'(bus_b.out_ready), bus_b.out_data, bus_b.drop_err);
  end

  initial begin
    reset = 1'b1;
`ifdef DEMUX_STREAM_COUNT_EN
    bus_a.cnt_sel = 3'd0;
    bus_b.cnt_sel = 3'd0;
`endif
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'hFF);
    applyStimulus(1, 1'b0, 3'd0, 8'h00, 8'hFF);
    repeat (2) tick();
    reset = 1'b0;
    #1;

    check("rst_out_valid_a", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_data_a",  32'(bus_a.out_data),  32'd0);
    check("rst_in_ready_a",  32'(bus_a.in_ready),  32'd1);
    check("rst_drop_err_a",  32'(bus_a.drop_err),  32'd0);
    check("rst_out_valid_b", 32'(bus_b.out_valid), 32'd0);
    check("rst_in_ready_b",  32'(bus_b.in_ready),  32'd1);
`ifdef DEMUX_STREAM_COUNT_EN
    check("rst_cnt_value_a", 32'(bus_a.cnt_value), 32'd0);
`endif

    // Full-rate stream through every channel, one cycle of latency each.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b1, 3'(i), 8'hA0 + 8'(i), 8'hFF);
      tick();
      check("stream_valid", 32'(bus_a.out_valid), 32'(8'd1 << i));
      check("stream_data",  32'(bus_a.out_data),  32'(8'hA0 + 8'(i)));
      check("stream_ready", 32'(bus_a.in_ready),  32'd1);
    end
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'hFF);
    tick();
    check("idle_valid", 32'(bus_a.out_valid), 32'd0);
    check("idle_data",  32'(bus_a.out_data),  32'hA7);

    // Channel 5 stalled for four cycles, then released with the next word waiting.
    applyStimulus(0, 1'b1, 3'd5, 8'h3C, 8'hDF);
    tick();
    applyStimulus(0, 1'b1, 3'd1, 8'h55, 8'hDF);
    for (int c = 0; c < 4; c++) begin
      check("stall_valid", 32'(bus_a.out_valid), 32'h20);
      check("stall_data",  32'(bus_a.out_data),  32'h3C);
      check("stall_ready", 32'(bus_a.in_ready),  32'd0);
      tick();
    end
    applyStimulus(0, 1'b1, 3'd1, 8'h55, 8'hFF);
    check("release_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("nobubble_valid", 32'(bus_a.out_valid), 32'h02);
    check("nobubble_data",  32'(bus_a.out_data),  32'h55);
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'hFF);
    tick();
    check("drained_valid", 32'(bus_a.out_valid), 32'd0);

    // Out-of-range selects on the 6-channel instance, including one during a drain.
    applyStimulus(1, 1'b1, 3'd6, 8'hE6, 8'hFF);
    tick();
    check("drop6_pulse", 32'(bus_b.drop_err),  32'd1);
    check("drop6_valid", 32'(bus_b.out_valid), 32'd0);
    applyStimulus(1, 1'b1, 3'd7, 8'hE7, 8'hFF);
    tick();
    check("drop7_pulse", 32'(bus_b.drop_err),  32'd1);
    check("drop7_valid", 32'(bus_b.out_valid), 32'd0);
    applyStimulus(1, 1'b1, 3'd2, 8'h22, 8'hFF);
    tick();
    check("after_drop_pulse", 32'(bus_b.drop_err),  32'd0);
    check("after_drop_valid", 32'(bus_b.out_valid), 32'h04);
    check("after_drop_data",  32'(bus_b.out_data),  32'h22);
    applyStimulus(1, 1'b1, 3'd6, 8'h66, 8'hFF);
    tick();
    check("drain_drop_valid", 32'(bus_b.out_valid), 32'd0);
    check("drain_drop_pulse", 32'(bus_b.drop_err),  32'd1);
    check("drain_drop_data",  32'(bus_b.out_data),  32'h22);
    applyStimulus(1, 1'b0, 3'd0, 8'h00, 8'hFF);
    tick();
    check("drop_single_cycle", 32'(bus_b.drop_err), 32'd0);

    // Reset while a word is stuck; the word offered during reset is lost too.
    applyStimulus(0, 1'b1, 3'd3, 8'h77, 8'h00);
    tick();
    check("prereset_valid", 32'(bus_a.out_valid), 32'h08);
    applyStimulus(0, 1'b1, 3'd2, 8'h99, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'h00);
    check("postreset_valid", 32'(bus_a.out_valid), 32'd0);
    check("postreset_ready", 32'(bus_a.in_ready),  32'd1);
    check("postreset_data",  32'(bus_a.out_data),  32'd0);
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'hFF);
    tick();

`ifdef DEMUX_STREAM_COUNT_EN
    applyStimulus(0, 1'b1, 3'd2, 8'h11, 8'hFF);
    repeat (3) tick();
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'hFF);
    tick();
    bus_a.cnt_sel = 3'd2;
    tick();
    check("cnt_ch2", 32'(bus_a.cnt_value), 32'd3);
    applyStimulus(0, 1'b1, 3'd1, 8'h5A, 8'hFF);
    repeat (65537) tick();
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'hFF);
    tick();
    bus_a.cnt_sel = 3'd1;
    tick();
    check("cnt_saturate", 32'(bus_a.cnt_value), 32'hFFFF);
`endif

    // Random traffic on both instances; the scoreboard covers ordering and one-hot.
    for (int n = 0; n < 10000; n++) begin
      bus_a.in_valid  = 1'($urandom_range(0, 1));
      bus_a.in_sel    = 3'($urandom_range(0, 7));
      bus_a.in_data   = 8'($urandom);
      bus_a.out_ready = 8'($urandom);
      bus_b.in_valid  = 1'($urandom_range(0, 1));
      bus_b.in_sel    = 3'($urandom_range(0, 7));
      bus_b.in_data   = 8'($urandom);
      bus_b.out_ready = 6'($urandom);
      tick();
    end
    applyStimulus(0, 1'b0, 3'd0, 8'h00, 8'hFF);
    applyStimulus(1, 1'b0, 3'd0, 8'h00, 8'hFF);
    repeat (3) tick();
    check("queue_empty_a", 32'(exp_q[0].size()), 32'd0);
    check("queue_empty_b", 32'(exp_q[1].size()), 32'd0);

`ifdef DEMUX_STREAM_COUNT_EN
    bus_b.cnt_sel = 3'd7;
    tick();
    check("cnt_out_of_range", 32'(bus_b.cnt_value), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..32.
REQ-002 Parameter NUM_OUT, default 8: number of output channels, legal range 2..16, not required to be a power of 2.
REQ-003 Parameter SEL_W, default 3: select width, which SHALL be >= ceil(log2(NUM_OUT)).
REQ-004 Port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: the upstream word is present.
REQ-007 Port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 Port in_sel, input, SEL_W bits: destination channel index.
REQ-009 Port in_data, input, DATA_W bits: payload.
REQ-010 Port out_valid, output, NUM_OUT bits: one-hot valid; bit k addresses channel k.
REQ-011 Port out_ready, input, NUM_OUT bits: per-channel downstream ready.
REQ-012 Port out_data, output, DATA_W bits: payload bus shared by all channels.
REQ-013 Port drop_err, output, 1 bit: one-cycle pulse when an out-of-range select was discarded.
REQ-014 Port cnt_sel, input, SEL_W bits: counter read index (present only with DEMUX_STREAM_COUNT_EN).
REQ-015 Port cnt_value, output, 16 bits: counter read data (present only with DEMUX_STREAM_COUNT_EN).

Function
REQ-016 A single holding stage SHALL store hold_valid, hold_sel and hold_data.
REQ-017 Accept SHALL occur when in_valid && in_ready.
REQ-018 in_ready SHALL equal !hold_valid || out_ready[hold_sel], evaluated combinationally.
REQ-019 out_valid SHALL equal the one-hot decode of hold_sel when hold_valid=1, else all zeros.
REQ-020 At most one out_valid bit SHALL be high in any cycle.
REQ-021 Drain of channel k SHALL occur when out_valid[k] && out_ready[k]; hold_valid clears on the next edge unless a new accept occurs in the same cycle.
REQ-022 Simultaneous drain and accept SHALL reload the stage with no bubble: sustained throughput is one word per cycle.
REQ-023 Latency from accept to out_valid SHALL be exactly 1 cycle.
REQ-024 While out_valid[k]=1 and out_ready[k]=0, out_data and out_valid SHALL stay stable.
REQ-025 out_ready bits of non-selected channels SHALL be ignored.
REQ-026 out_data SHALL hold the last loaded word when idle.
REQ-027 An accepted word with in_sel >= NUM_OUT SHALL NOT load the stage.
REQ-028 Such a word SHALL be consumed (accepted under the normal in_ready rule) and SHALL pulse drop_err high for exactly the following cycle.
REQ-029 Back-to-back out-of-range accepts SHALL produce back-to-back drop_err pulses.
REQ-030 An out-of-range accept in the same cycle as a drain SHALL leave hold_valid=0 after the edge.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL set hold_valid=0, hold_sel=0, hold_data=0, drop_err=0 and, if compiled in, all counters to 0.
REQ-032 Reset SHALL take priority over a simultaneous accept or drain, and the word presented in that cycle SHALL be lost.
REQ-033 After reset: out_valid=0, out_data=0, in_ready=1, cnt_value=0.

Configuration
REQ-034 With macro DEMUX_STREAM_COUNT_EN defined, the block SHALL keep one 16-bit counter per channel, incremented on each drain of that channel and saturating at 16'hFFFF.
REQ-035 With DEMUX_STREAM_COUNT_EN defined, cnt_value SHALL be the counter indexed by cnt_sel, registered with 1-cycle read latency, and SHALL read 0 for cnt_sel >= NUM_OUT.
REQ-036 Without DEMUX_STREAM_COUNT_EN, the counters and the cnt_sel/cnt_value ports SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Defaults, all out_ready=1, stream sel=0..7 with data=8'hA0+sel on consecutive cycles -> out_valid=8'h01,8'h02,...,8'h80 one cycle later, data matching, in_ready constantly 1.
REQ-038 sel=5, data=8'h3C, out_ready[5]=0 for 4 cycles -> out_valid=8'h20 and out_data=8'h3C stable, in_ready=0 for 4 cycles; drain then accepts the next word with no bubble.
REQ-039 NUM_OUT=6, SEL_W=3, sel=6 then sel=7 back-to-back -> two consecutive drop_err pulses, out_valid stays 0.
REQ-040 reset asserted while hold_valid=1 and out_ready=0 -> next cycle out_valid=0, in_ready=1, out_data=0.
REQ-041 DEMUX_STREAM_COUNT_EN defined, 3 drains on channel 2, then cnt_sel=2 -> cnt_value=3 one cycle later; force a counter to 16'hFFFF plus one drain -> it stays 16'hFFFF.
REQ-042 Random in_valid/out_ready at 50% for 10000 cycles, NUM_OUT=8 -> scoreboard shows in-order, lossless delivery per channel and never more than one out_valid bit high.
